// File: rtl/sw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sw_pkg: flit encodings, arbiter state type and polarity macros for the switch.
// Rev 1.0
// ---------------------------------------------------------------------------
`ifndef ASSERT
`define ASSERT 1'b1
`endif
`ifndef NEGATE
`define NEGATE 1'b0
`endif

package sw_pkg;

  localparam int PKTW = 9;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick: combinational round-robin selector, first request at or after ptr.
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NPORT = 4,
  localparam int GW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic             valid,
  output logic [GW-1:0]    idx
);

  logic [GW-1:0] w_cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      w_cand = ptr + GW'(k);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sw_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sw_arb: packet-granular round-robin output-port arbiter (head to tail grant).
// Optional stall-timeout abort: SW_ARB_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module sw_arb
  import sw_pkg::*;
#(
  parameter  int NPORT   = 4,
  parameter  int MY_PORT = 0,
  parameter  int TIMEOUT = 16,
  localparam int GW      = $clog2(NPORT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORT-1:0][PKTW:0]  pkti,
  input  logic [NPORT-1:0]          empty,
  output logic [NPORT-1:0]          re,
  output logic [PKTW:0]             pkto,
  output logic                      we,
  input  logic                      full,
  output logic                      busy,
  output logic [GW-1:0]             grant,
  output logic                      err
);

  state_t          r_state;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant;
  logic            r_busy;

  logic [NPORT-1:0] w_req;
  logic             w_valid;
  logic [GW-1:0]    w_idx;
  logic [PKTW:0]    w_flit;
  logic [1:0]       w_type;
  logic             w_pop;
  logic             w_fwd;
  logic             w_we;
  logic             w_tail;
  logic             w_abort;

  for (genvar i = 0; i < NPORT; i++) begin : g_req
    assign w_req[i] = !empty[i]
                      && (pkti[i][PKTW:PKTW-1] == FLIT_HEAD)
                      && (pkti[i][GW-1:0] == GW'(MY_PORT));
  end

  rr_pick #(.NPORT(NPORT)) u_pick (
    .req   (w_req),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  assign w_flit = pkti[r_grant];
  assign w_type = w_flit[PKTW:PKTW-1];
  assign w_pop  = (r_state == XFER) && !empty[r_grant] && !full;
  // Idle flits are popped but never written downstream.
  assign w_fwd  = (w_type == FLIT_HEAD) || (w_type == FLIT_BODY) || (w_type == FLIT_TAIL);
  assign w_we   = w_pop && w_fwd;
  assign w_tail = w_pop && (w_type == FLIT_TAIL);

  always_comb begin
    re = '0;
    if (w_pop) re[r_grant] = 1'b1;
  end

  assign we    = w_we ? `ASSERT : `NEGATE;
  assign pkto  = w_we ? w_flit : '0;
  assign busy  = r_busy;
  assign grant = r_grant;

`ifdef SW_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_abort = (r_state == XFER) && empty[r_grant] && (r_cnt == CW'(TIMEOUT - 1));
  assign err     = r_err ? `ASSERT : `NEGATE;

  // Only empty-input stalls age the grant; a full output is legitimate backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state != XFER) || w_pop || w_abort) begin
        r_cnt <= '0;
      end else if (empty[r_grant]) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_abort) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_abort          = 1'b0;
  assign err              = `NEGATE;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant <= w_idx;
            r_state <= XFER;
            r_busy  <= 1'b1;
          end
        end
        XFER: begin
          if (w_tail || w_abort) begin
            r_state <= IDLE;
            r_ptr   <= r_grant + GW'(1);
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sw_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sw_arb: scoreboard bench for sw_arb with FIFO models on each input.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sw_arb;
  import sw_pkg::*;

  localparam int NPORT = 4;
  localparam int GW    = 2;
  localparam int DEPTH = 32;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic full = 1'b0;
  logic [NPORT-1:0][PKTW:0] pkti;
  logic [NPORT-1:0] empty;
  logic [NPORT-1:0] re0, re1;
  logic [PKTW:0]    pkto0, pkto1;
  logic             we0, we1, busy0, busy1, err0, err1;
  logic [GW-1:0]    grant0, grant1;

  logic [PKTW:0] mem [NPORT][DEPTH];
  int            wp [NPORT];
  int            rp [NPORT];
  logic [PKTW:0] exp0[$];
  logic [PKTW:0] exp1[$];
  int            we_cyc[$];
  int            ex[$];
  logic [NPORT-1:0] pop_m;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int n_re00 = 0;
  int L;
  int snap;

  sw_arb #(.NPORT(NPORT), .MY_PORT(0), .TIMEOUT(16)) u_dut0 (
    .clk(clk), .rst(rst), .pkti(pkti), .empty(empty), .re(re0), .pkto(pkto0),
    .we(we0), .full(full), .busy(busy0), .grant(grant0), .err(err0)
  );

  sw_arb #(.NPORT(NPORT), .MY_PORT(1), .TIMEOUT(16)) u_dut1 (
    .clk(clk), .rst(rst), .pkti(pkti), .empty(empty), .re(re1), .pkto(pkto1),
    .we(we1), .full(full), .busy(busy1), .grant(grant1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expected flit whenever a DUT writes downstream.
  always @(negedge clk) begin
    logic [PKTW:0] e;
    if (cyc > 0) begin
      checks++;
      if (full && ((re0 != '0) || we0 || (re1 != '0) || we1)) begin
        errors++;
        $display("FAIL full_rule re0=%b we0=%b re1=%b we1=%b want all zero", re0, we0, re1, we1);
      end
      checks++;
      if (we0) begin
        we_cyc.push_back(cyc);
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL dut0_flit cyc=%0d got %h want none", cyc, pkto0);
        end else begin
          e = exp0.pop_front();
          if (pkto0 !== e) begin
            errors++;
            $display("FAIL dut0_flit cyc=%0d got %h want %h", cyc, pkto0, e);
          end
        end
      end else if (pkto0 !== '0) begin
        errors++;
        $display("FAIL dut0_pkto_idle cyc=%0d got %h want 0", cyc, pkto0);
      end
      checks++;
      if (we1) begin
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL dut1_flit cyc=%0d got %h want none", cyc, pkto1);
        end else begin
          e = exp1.pop_front();
          if (pkto1 !== e) begin
            errors++;
            $display("FAIL dut1_flit cyc=%0d got %h want %h", cyc, pkto1, e);
          end
        end
      end else if (pkto1 !== '0) begin
        errors++;
        $display("FAIL dut1_pkto_idle cyc=%0d got %h want 0", cyc, pkto1);
      end
      if (re0[0]) n_re00++;
    end
  end

  task automatic refresh();
    for (int i = 0; i < NPORT; i++) begin
      empty[i] = (wp[i] == rp[i]);
      pkti[i]  = (wp[i] == rp[i]) ? '0 : mem[i][rp[i] % DEPTH];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    pop_m = re0 | re1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NPORT; i++) if (pop_m[i]) rp[i]++;
    refresh();
  endtask

  // to: 0 expect on dut0, 1 expect on dut1, 2 never forwarded
  task automatic load(input int p, input logic [1:0] t, input logic [7:0] v, input int to);
    mem[p][wp[p] % DEPTH] = {t, v};
    wp[p]++;
    if (to == 0) exp0.push_back({t, v});
    else if (to == 1) exp1.push_back({t, v});
    refresh();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic run(input int start, input int n);
    for (int k = 0; k < n; k++) ex.push_back(start + k);
  endtask

  task automatic chk_cycles(input string name);
    bit ok;
    ok = (we_cyc.size() == ex.size());
    for (int i = 0; i < ex.size(); i++) if (ok && (we_cyc[i] != ex[i])) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s we_cycles got n=%0d first=%0d want n=%0d first=%0d", name,
               we_cyc.size(), (we_cyc.size() > 0) ? we_cyc[0] : -1,
               ex.size(), (ex.size() > 0) ? ex[0] : -1);
    end
    we_cyc.delete();
    ex.delete();
  endtask

  initial begin
    for (int i = 0; i < NPORT; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    refresh();
    repeat (2) tick();
    #1;
    chk("reset_busy",  32'(busy0),  0);
    chk("reset_grant", 32'(grant0), 0);
    chk("reset_we",    32'(we0),    0);
    chk("reset_re",    32'(re0),    0);
    chk("reset_err",   32'(err0),   0);
    rst = 1'b1;
    tick();
    we_cyc.delete();

    // Contention from ptr=0: input 1 then input 2 with one idle cycle between.
    L = cyc;
    load(1, FLIT_HEAD, 8'h10, 0); load(1, FLIT_BODY, 8'h11, 0);
    load(1, FLIT_BODY, 8'h12, 0); load(1, FLIT_TAIL, 8'h13, 0);
    load(2, FLIT_HEAD, 8'h20, 0); load(2, FLIT_BODY, 8'h21, 0);
    load(2, FLIT_BODY, 8'h22, 0); load(2, FLIT_TAIL, 8'h23, 0);
    repeat (2) tick();
    #1 chk("contend_grant1", 32'(grant0), 1);
    chk("contend_busy", 32'(busy0), 1);
    repeat (5) tick();
    #1 chk("contend_grant2", 32'(grant0), 2);
    repeat (5) tick();
    run(L + 1, 4); run(L + 6, 4);
    chk_cycles("contend");

    // ptr left at 3: input 3 beats input 0.
    L = cyc;
    load(0, FLIT_HEAD, 8'h30, 2); load(0, FLIT_TAIL, 8'h31, 2);
    load(3, FLIT_HEAD, 8'h40, 0); load(3, FLIT_TAIL, 8'h41, 0);
    exp0.push_back({FLIT_HEAD, 8'h30}); exp0.push_back({FLIT_TAIL, 8'h31});
    repeat (8) tick();
    run(L + 1, 2); run(L + 4, 2);
    chk_cycles("ptr_after_contend");

    // Single packet.
    L = cyc;
    load(0, FLIT_HEAD, 8'h00, 0); load(0, FLIT_BODY, 8'h00, 0);
    load(0, FLIT_BODY, 8'h01, 0); load(0, FLIT_TAIL, 8'h02, 0);
    repeat (6) tick();
    run(L + 1, 4);
    chk_cycles("single");
    #1 chk("single_busy_end", 32'(busy0), 0);

    // Idle flit inside a packet is popped and discarded.
    L = cyc;
    load(3, FLIT_HEAD, 8'hA0, 0); load(3, FLIT_IDLE, 8'h55, 2); load(3, FLIT_TAIL, 8'hA1, 0);
    repeat (5) tick();
    run(L + 1, 1); run(L + 3, 1);
    chk_cycles("idle_discard");
    chk("idle_drained", 32'(wp[3] - rp[3]), 0);

    // Backpressure: full for three cycles mid-packet.
    L = cyc;
    load(1, FLIT_HEAD, 8'h50, 0); load(1, FLIT_BODY, 8'h51, 0); load(1, FLIT_BODY, 8'h52, 0);
    load(1, FLIT_BODY, 8'h53, 0); load(1, FLIT_TAIL, 8'h54, 0);
    repeat (3) tick();
    full = 1'b1;
    #1 chk("bp_re", 32'(re0), 0);
    chk("bp_we", 32'(we0), 0);
    repeat (3) tick();
    full = 1'b0;
    #1 chk("bp_resume", 32'(we0), 1);
    repeat (4) tick();
    run(L + 1, 2); run(L + 6, 3);
    chk_cycles("backpressure");

    // Destination filter: head for port 1 is ignored by port 0, taken by port 1.
    snap = n_re00;
    load(0, FLIT_HEAD, 8'h91, 1); load(0, FLIT_TAIL, 8'h92, 1);
    repeat (5) tick();
    chk("dest_no_re_port0", 32'(n_re00 - snap), 0);
    chk("dest_port1_drained", 32'(wp[0] - rp[0]), 0);
    chk("dest_port1_done", 32'(exp1.size()), 0);
    we_cyc.delete();

    // Reset mid-packet on input 2 right after its second body flit.
    L = cyc;
    load(2, FLIT_HEAD, 8'h60, 0); load(2, FLIT_BODY, 8'h61, 0); load(2, FLIT_BODY, 8'h62, 0);
    load(2, FLIT_BODY, 8'h63, 2); load(2, FLIT_TAIL, 8'h64, 2);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1 chk("rst_mid_re", 32'(re0), 0);
    chk("rst_mid_we",    32'(we0),    0);
    chk("rst_mid_pkto",  32'(pkto0),  0);
    chk("rst_mid_grant", 32'(grant0), 0);
    chk("rst_mid_busy",  32'(busy0),  0);
    repeat (4) tick();
    chk("rst_mid_residue", 32'(wp[2] - rp[2]), 2);
    rp[2] = wp[2];
    refresh();
    run(L + 1, 3);
    chk_cycles("rst_mid");

`ifdef SW_ARB_TIMEOUT_EN
    // Input 2 starves after its head; input 1 waits behind it.
    L = cyc;
    load(2, FLIT_HEAD, 8'h70, 0);
    tick();
    load(1, FLIT_HEAD, 8'h80, 0); load(1, FLIT_TAIL, 8'h81, 0);
    repeat (16) tick();
    #1 chk("to_err_before", 32'(err0), 0);
    chk("to_busy_before", 32'(busy0), 1);
    tick();
    #1 chk("to_err", 32'(err0), 1);
    chk("to_idle", 32'(busy0), 0);
    tick();
    #1 chk("to_next_grant", 32'(grant0), 1);
    chk("to_next_we", 32'(we0), 1);
    repeat (3) tick();
    chk("to_err_sticky", 32'(err0), 1);
    we_cyc.delete();
`else
    chk("err_tied_low", 32'(err0), 0);
`endif

    chk("exp0_drained", 32'(exp0.size()), 0);
    chk("exp1_drained", 32'(exp1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sw_arb.md
# sw_arb

Output-port arbiter for the packet switch. It sits between the input FIFOs and one output port. It selects among input FIFOs whose head flit targets this port, using packet-granular round-robin, and holds the grant from head flit through tail flit. It drives the granted FIFO's `re` and the output FIFO's `we`, and honours the output FIFO's `full`. One instance per output port.

## Interface
- `NPORT`, default 4: number of input FIFOs and switch ports; power of 2.
- `MY_PORT`, default 0: output port index this instance serves.
- `TIMEOUT`, default 16: stall-cycle limit. Used only with `SW_ARB_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `pkti` in `NPORT`×(`PKTW`+1): head flit of each input FIFO (first-word fall-through, valid when `!empty[i]`).
- `empty` in `NPORT`: input FIFO empty flags.
- `re` out `NPORT`: input FIFO pop strobes, one-hot or zero.
- `pkto` out `PKTW`+1: flit to output FIFO.
- `we` out 1: output FIFO write strobe.
- `full` in 1: output FIFO full.
- `busy` out 1: grant held (state XFER).
- `grant` out log2(`NPORT`): current or last granted input.
- `err` out 1: sticky timeout abort flag. Tied 0 without `SW_ARB_TIMEOUT_EN`.

## Operation
- Flit type is `pkti[PKTW:PKTW-1]`: 2'b10 head, 2'b01 body, 2'b11 tail, 2'b00 idle.
- Destination is the head flit's `[log2(NPORT)-1:0]`.
- `req[i] = !empty[i] && type==head && dest==MY_PORT`.

**State IDLE**
- No pops, `we=0`.
- If any `req`: pick the first set `req` at or after `ptr`, cyclically. Register it into `grant` and go to XFER.

**State XFER**
- Each cycle with `!empty[grant] && !full`: `re[grant]=1`, `pkto=pkti[grant]`, `we=1`, except:
  - An idle flit is popped with `we=0` (discarded).
- When the popped flit is a tail: go to IDLE and set `ptr=grant+1` (mod `NPORT`).
- `empty[grant]` or `full` stalls the transfer: `re=0`, `we=0`, state held.
- A head flit arriving mid-packet is forwarded as data. The packet ends only on a tail.

**Common rules**
- `pkto` is combinational from `pkti[grant]` and is 0 whenever `we=0`.
- `re` and `we` are never asserted while `full=1`.
- Requests from other inputs are ignored during XFER. Their flits stay in their FIFOs.

**Reset** (`rst` low at a clock edge):
- State IDLE; `ptr=0`, `grant=0`, `err=0`, `busy=0`.
- `re=0`, `we=0`, `pkto=0`.
- Reset mid-packet abandons the packet. Residual flits stay in the FIFO and are not requests unless they are heads.

## Timing
- Arbitration takes 1 cycle: a request seen in IDLE at edge N gives the first pop (the head) in cycle N+1.
- Streaming throughput is 1 flit/cycle with no bubbles.
- The packet following a tail is arbitrated in the cycle after the tail pop. Per-packet overhead is 1 idle cycle.
- `full` and `empty` act in the same cycle: no skid, no buffering inside the block.
- A packet of L flits with no stalls occupies L+1 cycles: 1 arbitration cycle plus L transfer cycles.
- Simultaneous requests resolve by `ptr` only. After serving input i, input i has the lowest priority.

## Configuration
- `SW_ARB_TIMEOUT_EN` defined:
  - A stall counter (width clog2(`TIMEOUT`+1)) counts XFER cycles with `empty[grant]`. It resets on every pop.
  - At `TIMEOUT`, the block forces IDLE, sets `ptr=grant+1`, and sets `err`, which holds until reset.
  - The output packet is left without a tail. Downstream treats `err` as a flush cue.
  - Stalls caused by `full` do not count.
- `SW_ARB_TIMEOUT_EN` undefined: no counter. The grant is held indefinitely. `err=0`.

## Structure
- Shared package `sw_pkg`:
  - flit type constants `FLIT_IDLE`, `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`;
  - state enum `{IDLE, XFER}`;
  - `PKTW`, taken from `sw.vh`.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs `req[NPORT]` and `ptr`; outputs `valid` and `idx`. It is reused by the other output ports' arbiters.
- Assertion polarity follows the `ASSERT`/`NEGATE` macros from `sw.vh`.

## Test plan
1. **Single packet.** Input 0 holds `10_0000_0000`, `01_0000_0000`, `01_0000_0001`, `11_0000_0010`; `MY_PORT`=0. Required: 4 consecutive `we` cycles starting 1 cycle after request, `pkto` equal to those four flits in order, then `busy`=0.
2. **Contention.** Inputs 1 and 2 each hold a 4-flit packet to port 0, `ptr`=0. Required: input 1's packet is output contiguously, then input 2's after exactly 1 idle cycle, and `ptr` ends at 3.
3. **Backpressure.** `full`=1 for 3 cycles mid-packet. Required: `re`=`we`=0 during those cycles, no flit lost or duplicated, and streaming resumes in the cycle `full` drops.
4. **Destination filter.** Input 0 head `10_1001_0001` (dest 1) with `MY_PORT`=0. Required: no `re` on input 0; an arbiter with `MY_PORT`=1 forwards it.
5. **Reset mid-packet.** Assert `rst` low after the 2nd body flit. Required: next cycle `re`=0, `we`=0, `pkto`=0, `grant`=0, `busy`=0; the remaining tail is not forwarded.
6. **Timeout** (`SW_ARB_TIMEOUT_EN`, `TIMEOUT`=16). Granted input goes empty after its head. Required: after 16 stall cycles `err`=1 and state is IDLE; a waiting input 1 packet is then granted.
